uart_tx: RTL and testbench

Buffered UART transmitter on the processor's memory-mapped I/O path, downstream of the CPU's store side; it drives the SOC `TXD` pin. The CPU writes bytes into a 4-entry FIFO; an independent serializer emits 8N1 frames, LSB first, at a fixed clocks-per-bit rate. Status outputs (`full`, `busy`, `overflow`) are readable by firmware through the I/O decoder.

---
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a 4-entry byte FIFO feeding a serializer
// that emits LSB-first frames at CLKS_PER_BIT clocks per bit on o_txd.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_wdata,
  input  logic       i_wstrb,
  output logic       o_full,
  output logic [2:0] o_level,
  output logic       o_busy,
  output logic       o_overflow,
  output logic       o_txd
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      r_state, w_stateNext;
  logic [7:0]  r_fifo [4];
  logic [1:0]  r_wrPtr, r_rdPtr;
  logic [2:0]  r_count, w_countNext;
  logic [15:0] r_baud, w_baudNext;
  logic [2:0]  r_bitIdx, w_bitIdxNext;
  logic [7:0]  r_shift, w_shiftNext;
  logic        r_txd, r_busy, r_full, r_overflow;
  logic        w_pop, w_push, w_txdNext, w_baudDone;

  assign w_baudDone = (r_baud == BAUD_LAST);

  always_comb begin
    w_stateNext  = r_state;
    w_baudNext   = r_baud;
    w_bitIdxNext = r_bitIdx;
    w_shiftNext  = r_shift;
    w_pop        = 1'b0;
    w_txdNext    = 1'b1;
    case (r_state)
      IDLE: begin
        if (r_count != 3'd0) begin
          w_pop       = 1'b1;
          w_shiftNext = r_fifo[r_rdPtr];
          w_stateNext = START;
          w_baudNext  = 16'd0;
        end
      end
      START: begin
        w_txdNext = 1'b0;
        if (w_baudDone) begin
          w_baudNext   = 16'd0;
          w_bitIdxNext = 3'd0;
          w_stateNext  = DATA;
        end else begin
          w_baudNext = r_baud + 16'd1;
        end
      end
      DATA: begin
        w_txdNext = r_shift[0];
        if (w_baudDone) begin
          w_baudNext  = 16'd0;
          w_shiftNext = {1'b0, r_shift[7:1]};
          if (r_bitIdx == 3'd7) begin
            w_stateNext = STOP;
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
          end
        end else begin
          w_baudNext = r_baud + 16'd1;
        end
      end
      STOP: begin
        w_txdNext = 1'b1;
        if (w_baudDone) begin
          w_baudNext = 16'd0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap
          if (r_count != 3'd0) begin
            w_pop       = 1'b1;
            w_shiftNext = r_fifo[r_rdPtr];
            w_stateNext = START;
          end else begin
            w_stateNext = IDLE;
          end
        end else begin
          w_baudNext = r_baud + 16'd1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // A pop on the same edge frees the slot, so a write seen while full still lands then
  assign w_push = i_wstrb && ((r_count != 3'd4) || w_pop);

  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + 3'd1;
      2'b01:   w_countNext = r_count - 3'd1;
      default: w_countNext = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_reset) begin
      r_fifo[r_wrPtr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_wrPtr    <= 2'd0;
      r_rdPtr    <= 2'd0;
      r_count    <= 3'd0;
      r_baud     <= 16'd0;
      r_bitIdx   <= 3'd0;
      r_shift    <= 8'd0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_baud   <= w_baudNext;
      r_bitIdx <= w_bitIdxNext;
      r_shift  <= w_shiftNext;
      r_count  <= w_countNext;
      r_full   <= (w_countNext == 3'd4);
      r_txd    <= w_txdNext;
      r_busy   <= (r_state != IDLE) || (r_count != 3'd0);
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 2'd1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 2'd1;
      end
      if (i_wstrb && (r_count == 3'd4)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_full     = r_full;
  assign o_level    = r_count;
  assign o_busy     = r_busy;
  assign o_overflow = r_overflow;
  assign o_txd      = r_txd;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a fast-baud instance with a frame-decoding monitor and
// scoreboard, plus a 104 clocks-per-bit instance for real-rate timing.
module tb_uart_tx;
  localparam int CPB      = 4;
  localparam int CPB_LONG = 104;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wdataA, wdataB;
  logic       wstrbA, wstrbB;
  logic       fullA, busyA, overflowA, txdA;
  logic       fullB, busyB, overflowB, txdB;
  logic [2:0] levelA, levelB;

  int         checks = 0;
  int         errors = 0;
  int         cycle = 0;
  logic [7:0] expQ[$];
  logic [7:0] expQB[$];
  int         frameStarts[$];
  bit         monEnable = 1'b0;

  uart_tx #(.CLKS_PER_BIT(CPB)) dutA (
    .i_clk(clk), .i_reset(reset), .i_wdata(wdataA), .i_wstrb(wstrbA),
    .o_full(fullA), .o_level(levelA), .o_busy(busyA),
    .o_overflow(overflowA), .o_txd(txdA)
  );

  uart_tx #(.CLKS_PER_BIT(CPB_LONG)) dutB (
    .i_clk(clk), .i_reset(reset), .i_wdata(wdataB), .i_wstrb(wstrbB),
    .o_full(fullB), .o_level(levelB), .o_busy(busyB),
    .o_overflow(overflowB), .o_txd(txdB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Decodes every frame on txdA cycle by cycle and scores it against expQ
  initial begin : monitorA
    logic [7:0] data;
    logic [7:0] expByte;
    logic       smp;
    bit         bad;
    forever begin
      @(negedge clk);
      if (monEnable && txdA === 1'b0) begin
        frameStarts.push_back(cycle);
        bad  = 1'b0;
        data = 8'h00;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            smp = txdA;
            if (b == 0) begin
              if (smp !== 1'b0) bad = 1'b1;
            end else if (b == 9) begin
              if (smp !== 1'b1) bad = 1'b1;
            end else if (s == 0) begin
              data[b-1] = smp;
            end else if (smp !== data[b-1]) begin
              bad = 1'b1;
            end
          end
        end
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL frame_unexpected: got 0x%02h, required no frame", data);
        end else begin
          expByte = expQ.pop_front();
          if (bad || data !== expByte) begin
            errors++;
            $display("[TB] FAIL frame_data: got 0x%02h (malformed=%0d), required 0x%02h", data, bad, expByte);
          end
        end
      end
    end
  end

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    @(negedge clk);
    reset  = 1'b1;
    wstrbA = 1'b1;
    wdataA = 8'hAA;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    wstrbA = 1'b0;
    checks++; if (txdA !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd: got %0b, required 1", txdA); end
    checks++; if (levelA !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d, required 0", levelA); end
    checks++; if (fullA !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %0b, required 0", fullA); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b, required 0", busyA); end
    checks++; if (overflowA !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0b, required 0", overflowA); end
    checks++; if (txdB !== 1'b1 || levelB !== 3'd0) begin errors++; $display("[TB] FAIL reset_b: got txd=%0b level=%0d, required 1/0", txdB, levelB); end
    monEnable = 1'b1;
  endtask

  task automatic test_single_frame();
    logic [7:0] pat = 8'h55;
    logic       expBit;
    $display("[TB] test_single_frame");
    expQ.push_back(8'h55);
    wdataA = 8'h55;
    wstrbA = 1'b1;
    @(negedge clk);
    wstrbA = 1'b0;
    checks++; if (levelA !== 3'd1) begin errors++; $display("[TB] FAIL single_level: got %0d, required 1", levelA); end
    for (int i = 0; i < 46; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 2)       expBit = 1'b1;
      else if (i < 6)  expBit = 1'b0;
      else if (i < 38) expBit = pat[(i - 6) / 4];
      else             expBit = 1'b1;
      checks++;
      if (txdA !== expBit) begin
        errors++;
        $display("[TB] FAIL single_txd[%0d]: got %0b, required %0b", i, txdA, expBit);
      end
      if (i == 20) begin
        checks++; if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_mid: got %0b, required 1", busyA); end
      end
      if (i == 45) begin
        checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_end: got %0b, required 0", busyA); end
      end
    end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL single_pending: got %0d bytes left, required 0", expQ.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
    int         maxLevel = 0;
    bit         sawFull = 1'b0;
    $display("[TB] test_back_to_back");
    frameStarts.delete();
    for (int k = 0; k < 4; k++) begin
      expQ.push_back(bytes[k]);
      wdataA = bytes[k];
      wstrbA = 1'b1;
      @(negedge clk);
      if (int'(levelA) > maxLevel) maxLevel = int'(levelA);
      if (fullA === 1'b1) sawFull = 1'b1;
    end
    wstrbA = 1'b0;
    for (int i = 0; i < 170; i++) begin
      @(negedge clk);
      if (int'(levelA) > maxLevel) maxLevel = int'(levelA);
      if (fullA === 1'b1) sawFull = 1'b1;
    end
    checks++; if (maxLevel != 3) begin errors++; $display("[TB] FAIL b2b_max_level: got %0d, required 3", maxLevel); end
    checks++; if (sawFull) begin errors++; $display("[TB] FAIL b2b_full_seen: got 1, required 0"); end
    checks++;
    if (frameStarts.size() != 4) begin
      errors++;
      $display("[TB] FAIL b2b_frame_count: got %0d, required 4", frameStarts.size());
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (frameStarts[k] - frameStarts[k-1] != 10 * CPB) begin
          errors++;
          $display("[TB] FAIL b2b_gap[%0d]: got %0d cycles, required %0d", k, frameStarts[k] - frameStarts[k-1], 10 * CPB);
        end
      end
    end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL b2b_pending: got %0d bytes left, required 0", expQ.size()); end
  endtask

  task automatic test_overflow();
    $display("[TB] test_overflow");
    for (int k = 0; k < 6; k++) begin
      if (k < 5) expQ.push_back(8'(8'h10 + k));
      wdataA = 8'(8'h10 + k);
      wstrbA = 1'b1;
      @(negedge clk);
      if (k == 4) begin
        checks++; if (overflowA !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %0b, required 0", overflowA); end
      end
    end
    wstrbA = 1'b0;
    checks++; if (fullA !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full: got %0b, required 1", fullA); end
    checks++; if (levelA !== 3'd4) begin errors++; $display("[TB] FAIL ovf_level: got %0d, required 4", levelA); end
    checks++; if (overflowA !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %0b, required 1", overflowA); end
    repeat (210) @(negedge clk);
    checks++; if (overflowA !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %0b, required 1", overflowA); end
    checks++; if (levelA !== 3'd0 || fullA !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained: got level=%0d full=%0b, required 0/0", levelA, fullA); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL ovf_busy: got %0b, required 0", busyA); end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL ovf_pending: got %0d bytes left, required 0", expQ.size()); end
  endtask

  task automatic test_full_pop_write();
    $display("[TB] test_full_pop_write");
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      expQ.push_back(8'(8'h21 + k));
      wdataA = 8'(8'h21 + k);
      wstrbA = 1'b1;
      @(negedge clk);
    end
    wstrbA = 1'b0;
    // The first frame's final stop edge is 40 edges after its pop
    repeat (36) @(negedge clk);
    checks++; if (levelA !== 3'd4 || overflowA !== 1'b0) begin errors++; $display("[TB] FAIL fpw_before: got level=%0d ovf=%0b, required 4/0", levelA, overflowA); end
    expQ.push_back(8'h26);
    wdataA = 8'h26;
    wstrbA = 1'b1;
    @(negedge clk);
    wstrbA = 1'b0;
    checks++; if (levelA !== 3'd4) begin errors++; $display("[TB] FAIL fpw_level: got %0d, required 4", levelA); end
    checks++; if (overflowA !== 1'b1) begin errors++; $display("[TB] FAIL fpw_overflow: got %0b, required 1", overflowA); end
    repeat (240) @(negedge clk);
    checks++; if (levelA !== 3'd0) begin errors++; $display("[TB] FAIL fpw_drained: got %0d, required 0", levelA); end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL fpw_pending: got %0d bytes left, required 0", expQ.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int stray = 0;
    $display("[TB] test_reset_mid_frame");
    pulse_reset();
    monEnable = 1'b0;
    wdataA = 8'hA5; wstrbA = 1'b1; @(negedge clk);
    wdataA = 8'hB6; @(negedge clk);
    wdataA = 8'hC7; @(negedge clk);
    wstrbA = 1'b0;
    repeat (16) @(negedge clk);
    checks++; if (txdA !== 1'b0 || levelA !== 3'd2) begin errors++; $display("[TB] FAIL mid_bit3: got txd=%0b level=%0d, required 0/2", txdA, levelA); end
    reset  = 1'b1;
    wstrbA = 1'b1;
    wdataA = 8'h33;
    @(negedge clk);
    checks++; if (txdA !== 1'b1) begin errors++; $display("[TB] FAIL mid_txd: got %0b, required 1", txdA); end
    checks++; if (levelA !== 3'd0 || fullA !== 1'b0) begin errors++; $display("[TB] FAIL mid_level: got %0d, required 0", levelA); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %0b, required 0", busyA); end
    checks++; if (overflowA !== 1'b0) begin errors++; $display("[TB] FAIL mid_overflow: got %0b, required 0", overflowA); end
    reset  = 1'b0;
    wstrbA = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txdA !== 1'b1 || busyA !== 1'b0) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("[TB] FAIL mid_quiet: got %0d active cycles, required 0", stray); end
    monEnable = 1'b1;
  endtask

  task automatic test_long_baud();
    logic       s [1100];
    int         firstLow = -1;
    int         startLen = 0;
    int         lastLow = -1;
    logic [7:0] decoded = 8'h00;
    logic [7:0] expByte;
    $display("[TB] test_long_baud");
    expQB.push_back(8'h41);
    wdataB = 8'h41;
    wstrbB = 1'b1;
    @(negedge clk);
    wstrbB = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (i > 0) @(negedge clk);
      s[i] = txdB;
      if (s[i] === 1'b0) begin
        if (firstLow < 0) firstLow = i;
        lastLow = i;
      end
    end
    checks++;
    if (firstLow != 2) begin
      errors++;
      $display("[TB] FAIL long_start_latency: got %0d, required 2", firstLow);
    end else begin
      for (int i = firstLow; i < 1100 && s[i] === 1'b0; i++) startLen++;
      for (int k = 0; k < 8; k++) decoded[k] = s[firstLow + CPB_LONG * (k + 1) + CPB_LONG / 2];
      checks++; if (startLen != CPB_LONG) begin errors++; $display("[TB] FAIL long_start_len: got %0d, required %0d", startLen, CPB_LONG); end
      checks++; if (lastLow != firstLow + 9 * CPB_LONG - 1) begin errors++; $display("[TB] FAIL long_last_low: got %0d, required %0d", lastLow, firstLow + 9 * CPB_LONG - 1); end
      checks++; if (s[firstLow + 10 * CPB_LONG - 1] !== 1'b1) begin errors++; $display("[TB] FAIL long_stop: got %0b, required 1", s[firstLow + 10 * CPB_LONG - 1]); end
      expByte = expQB.pop_front();
      checks++; if (decoded !== expByte) begin errors++; $display("[TB] FAIL long_data: got 0x%02h, required 0x%02h", decoded, expByte); end
    end
    checks++; if (busyB !== 1'b0) begin errors++; $display("[TB] FAIL long_busy: got %0b, required 0", busyB); end
  endtask

  initial begin
    reset  = 1'b1;
    wdataA = 8'h00;
    wstrbA = 1'b0;
    wdataB = 8'h00;
    wstrbB = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_full_pop_write();
    test_reset_mid_frame();
    test_long_baud();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
